// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizes for the four-core SSRAM arbiter.
// Holds the controller state encoding, default bus widths and the latency counter width.
package mem_arbiter_pkg;
  localparam int NCORE_MAX  = 4;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 3;
  localparam int IDX_W      = $clog2(NCORE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request bus of the shared-memory arbiter: one request lane per core
// plus the common read-data return.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int NCORE  = NCORE_MAX,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  // Handshake: a core raises req[k] (with we/addr/wdata) and holds it until the
  // arbiter returns a one-cycle done[k]; rdata is valid only in that cycle, and
  // stall[k] = req[k] & ~done[k] holds the core's pipeline meanwhile.
  logic [NCORE-1:0]             req;
  logic [NCORE-1:0]             we;
  logic [NCORE-1:0][ADDR_W-1:0] addr;
  logic [NCORE-1:0][DATA_W-1:0] wdata;
  logic [NCORE-1:0]             stall;
  logic [NCORE-1:0]             done;
  logic [DATA_W-1:0]            rdata;

  modport master (output req, we, addr, wdata, input stall, done, rdata);
  modport slave  (input req, we, addr, wdata, output stall, done, rdata);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search begins one past the pointer and
// wraps modulo NCORE; returns a one-hot grant and its encoded index.
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCORE = NCORE_MAX
) (
  input  logic [NCORE-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NCORE-1:0] gnt,
  output logic [IDX_W-1:0] idx
);
  always_comb begin : rr_search
    logic [IDX_W-1:0] k;
    logic             found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= NCORE; i++) begin
      k = IDX_W'((int'(ptr) + i) % NCORE);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin SSRAM controller shared by up to four cores; one access at a time.
// Define MEM_ARBITER_SNOOP_INV_EN to broadcast cache invalidates on every write.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCORE    = NCORE_MAX,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SRAM_LAT = 2
) (
  input  logic              new_clock,
  input  logic              reset_n,
  mem_arbiter_if.slave      cpu,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wd,
  input  logic [DATA_W-1:0] sram_rd,
  output logic              sram_gw,
  output logic              sram_oe,
  output logic              inv_valid,
  output logic [NCORE-1:0]  inv_mask,
  output logic [ADDR_W-1:0] inv_addr,
  output state_e            dbg_state
);
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NCORE-1:0]  gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wd_q, sram_wd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              sram_gw_q, sram_gw_d;
  logic              sram_oe_q, sram_oe_d;
  logic [NCORE-1:0]  done_q, done_d;
  logic [NCORE-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;

  rr_arbiter #(.NCORE(NCORE)) u_rr (
    .req (cpu.req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Outputs are registered, so the ACCESS-cycle strobes are set on the grant edge.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    sram_addr_d = sram_addr_q;
    sram_wd_d   = sram_wd_q;
    rdata_d     = rdata_q;
    sram_gw_d   = 1'b0;
    sram_oe_d   = 1'b0;
    done_d      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|cpu.req) begin
          ptr_d       = arb_idx;
          gnt_d       = arb_gnt;
          we_d        = cpu.we[arb_idx];
          sram_addr_d = cpu.addr[arb_idx];
          if (cpu.we[arb_idx]) begin
            sram_gw_d = 1'b1;
            sram_wd_d = cpu.wdata[arb_idx];
          end else begin
            sram_oe_d = 1'b1;
          end
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          done_d  = gnt_q;
          state_d = ST_RESP;
        end else begin
          sram_oe_d = 1'b1;
          cnt_d     = CNT_W'(SRAM_LAT - 1);
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = sram_rd;
          done_d  = gnt_q;
          state_d = ST_RESP;
        end else begin
          sram_oe_d = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge new_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NCORE - 1);
      gnt_q       <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      sram_addr_q <= '0;
      sram_wd_q   <= '0;
      rdata_q     <= '0;
      sram_gw_q   <= 1'b0;
      sram_oe_q   <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      sram_addr_q <= sram_addr_d;
      sram_wd_q   <= sram_wd_d;
      rdata_q     <= rdata_d;
      sram_gw_q   <= sram_gw_d;
      sram_oe_q   <= sram_oe_d;
      done_q      <= done_d;
    end
  end

`ifdef MEM_ARBITER_SNOOP_INV_EN
  logic              inv_valid_q, inv_valid_d;
  logic [NCORE-1:0]  inv_mask_q, inv_mask_d;
  logic [ADDR_W-1:0] inv_addr_q, inv_addr_d;

  // Raised together with sram_gw: every core except the writer drops its copy.
  always_comb begin
    inv_valid_d = 1'b0;
    inv_mask_d  = '0;
    inv_addr_d  = '0;
    if (state_q == ST_IDLE && (|cpu.req) && cpu.we[arb_idx]) begin
      inv_valid_d = 1'b1;
      inv_mask_d  = ~arb_gnt;
      inv_addr_d  = cpu.addr[arb_idx];
    end
  end

  always_ff @(posedge new_clock or negedge reset_n) begin
    if (!reset_n) begin
      inv_valid_q <= 1'b0;
      inv_mask_q  <= '0;
      inv_addr_q  <= '0;
    end else begin
      inv_valid_q <= inv_valid_d;
      inv_mask_q  <= inv_mask_d;
      inv_addr_q  <= inv_addr_d;
    end
  end

  assign inv_valid = inv_valid_q;
  assign inv_mask  = inv_mask_q;
  assign inv_addr  = inv_addr_q;
`else
  assign inv_valid = 1'b0;
  assign inv_mask  = '0;
  assign inv_addr  = '0;
`endif

  assign cpu.stall = cpu.req & ~done_q;
  assign cpu.done  = done_q;
  assign cpu.rdata = rdata_q;
  assign sram_addr = sram_addr_q;
  assign sram_wd   = sram_wd_q;
  assign sram_gw   = sram_gw_q;
  assign sram_oe   = sram_oe_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized multi-core traffic,
// checked every cycle against a transaction-timeline model of the arbiter.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int NCORE    = 4;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 32;
  localparam int SRAM_LAT = 2;

  // ---------------- clock / reset ----------------
  logic new_clock = 1'b0;
  logic reset_n   = 1'b1;
  always #5 new_clock = ~new_clock;

  mem_arbiter_if #(.NCORE(NCORE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wd;
  logic [DATA_W-1:0] sram_rd;
  logic              sram_gw;
  logic              sram_oe;
  logic              inv_valid;
  logic [NCORE-1:0]  inv_mask;
  logic [ADDR_W-1:0] inv_addr;
  state_e            dbg_state;

  mem_arbiter #(
    .NCORE(NCORE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_LAT(SRAM_LAT)
  ) dut (
    .new_clock (new_clock),
    .reset_n   (reset_n),
    .cpu       (cpu_if.slave),
    .sram_addr (sram_addr),
    .sram_wd   (sram_wd),
    .sram_rd   (sram_rd),
    .sram_gw   (sram_gw),
    .sram_oe   (sram_oe),
    .inv_valid (inv_valid),
    .inv_mask  (inv_mask),
    .inv_addr  (inv_addr),
    .dbg_state (dbg_state)
  );

  function automatic logic [31:0] init_word(input logic [5:0] a);
    if (a == 6'h05) return 32'hDEADBEEF;
    return {2'b10, a, 8'h5A, 2'b01, a, 8'hC3};
  endfunction

  // ---------------- SSRAM model: fixed read latency ----------------
  logic [DATA_W-1:0] sram_mem [64];
  bit                written  [64];
  logic [DATA_W-1:0] rd_pipe  [SRAM_LAT];

  always @(posedge new_clock) begin
    if (sram_gw) begin
      sram_mem[sram_addr] <= sram_wd;
      written[sram_addr]  <= 1'b1;
    end
    rd_pipe[0] <= sram_oe ? (written[sram_addr] ? sram_mem[sram_addr] : init_word(sram_addr))
                          : 32'hBAADF00D;
    for (int i = 1; i < SRAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rd = rd_pipe[SRAM_LAT-1];

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_log [$];

  logic [DATA_W-1:0] ref_mem [64];
  bit                m_busy;
  int                m_tg, m_g, m_ptr;
  bit                m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wd, m_rdata;

  logic [NCORE-1:0]  last_done, keep_req;
  bit                rand_mode;

  logic [NCORE-1:0]  snap_done, snap_stall, snap_inv_m;
  logic              snap_gw, snap_oe, snap_inv_v;
  logic [ADDR_W-1:0] snap_addr, snap_inv_a;
  logic [DATA_W-1:0] snap_wd, snap_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_ptr     = NCORE - 1;
    m_rdata   = '0;
    last_done = '0;
  endtask

  task automatic new_fields(input int k);
    cpu_if.we[k]    = 1'($urandom_range(0, 1));
    cpu_if.addr[k]  = ADDR_W'($urandom_range(0, 15));
    cpu_if.wdata[k] = $urandom;
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    for (int k = 0; k < NCORE; k++) begin
      if (last_done[k]) begin
        bit drop;
        drop = rand_mode ? ($urandom_range(0, 1) == 0) : !keep_req[k];
        if (drop) cpu_if.req[k] = 1'b0;
        else if (rand_mode) new_fields(k);
      end else if (rand_mode) begin
        if (!cpu_if.req[k] && $urandom_range(0, 2) == 0) begin
          cpu_if.req[k] = 1'b1;
          new_fields(k);
        end else if (cpu_if.req[k] && m_busy && m_g == k && $urandom_range(0, 1) == 1) begin
          new_fields(k);
        end
      end
    end
  endtask

  // One clock: compare outputs against the access timeline, advance model, drive.
  task automatic cycle();
    logic [NCORE-1:0] e_done, e_stall, e_mask;
    logic             e_gw, e_oe, e_inv;
    bit               fin;
    int               ph;
    @(negedge new_clock);
    snap_done  = cpu_if.done;
    snap_stall = cpu_if.stall;
    snap_rdata = cpu_if.rdata;
    snap_gw    = sram_gw;
    snap_oe    = sram_oe;
    snap_addr  = sram_addr;
    snap_wd    = sram_wd;
    snap_inv_v = inv_valid;
    snap_inv_m = inv_mask;
    snap_inv_a = inv_addr;
    e_done = '0; e_mask = '0; e_gw = 1'b0; e_oe = 1'b0; e_inv = 1'b0; fin = 1'b0;
    if (m_busy) begin
      ph = cyc - m_tg;
      if (m_we) begin
        if (ph == 1) begin
          e_gw = 1'b1;
`ifdef MEM_ARBITER_SNOOP_INV_EN
          e_inv  = 1'b1;
          e_mask = ~(NCORE'(1) << m_g);
`endif
          ref_mem[m_addr] = m_wd;
        end else if (ph == 2) begin
          e_done[m_g] = 1'b1;
          fin = 1'b1;
        end
      end else begin
        if (ph >= 1 && ph <= SRAM_LAT + 1) e_oe = 1'b1;
        else if (ph == SRAM_LAT + 2) begin
          m_rdata = ref_mem[m_addr];
          e_done[m_g] = 1'b1;
          fin = 1'b1;
        end
      end
    end
    e_stall = cpu_if.req & ~e_done;

    chk("done", snap_done, e_done);
    chk("stall", snap_stall, e_stall);
    chk("sram_gw", snap_gw, e_gw);
    chk("sram_oe", snap_oe, e_oe);
    if (e_gw || e_oe) chk("sram_addr", snap_addr, m_addr);
    if (e_gw) chk("sram_wd", snap_wd, m_wd);
    if (|e_done) chk("rdata", snap_rdata, m_rdata);
    chk("inv_valid", snap_inv_v, e_inv);
`ifdef MEM_ARBITER_SNOOP_INV_EN
    if (e_inv) begin
      chk("inv_mask", snap_inv_m, e_mask);
      chk("inv_addr", snap_inv_a, m_addr);
    end
`else
    chk("inv_mask", snap_inv_m, '0);
    chk("inv_addr", snap_inv_a, '0);
`endif

    if (fin) m_busy = 1'b0;
    else if (!m_busy && (|cpu_if.req)) begin
      for (int i = 1; i <= NCORE; i++) begin
        int k;
        k = (m_ptr + i) % NCORE;
        if (!m_busy && cpu_if.req[k]) begin
          m_busy = 1'b1; m_tg = cyc; m_g = k; m_ptr = k;
          m_we = cpu_if.we[k]; m_addr = cpu_if.addr[k]; m_wd = cpu_if.wdata[k];
        end
      end
    end
    for (int k = 0; k < NCORE; k++) if (snap_done[k]) done_log.push_back(k);
    last_done = e_done;
    cyc++;
    @(posedge new_clock);
    #1;
    drive();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    while ((m_busy || (|cpu_if.req)) && n < max_cycles) begin
      cycle();
      n++;
    end
    chk("drain_timeout", {62'd0, m_busy, |cpu_if.req}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_done"}, cpu_if.done, '0);
    chk({tag, "_stall"}, cpu_if.stall, '0);
    chk({tag, "_rdata"}, cpu_if.rdata, '0);
    chk({tag, "_sram"}, {sram_gw, sram_oe, sram_addr, sram_wd}, '0);
    chk({tag, "_inv"}, {inv_valid, inv_mask, inv_addr}, '0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    cpu_if.req   = '0;
    cpu_if.we    = '0;
    cpu_if.addr  = '0;
    cpu_if.wdata = '0;
    keep_req     = '0;
    #1;
    check_all_zero("reset");
    model_reset();
    repeat (2) @(posedge new_clock);
    @(negedge new_clock);
    reset_n = 1'b1;
    @(posedge new_clock);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0, stall_cnt, done_at;
    logic [DATA_W-1:0] rd_val;
    for (int a = 0; a < 64; a++) ref_mem[a] = init_word(ADDR_W'(a));
    rand_mode = 1'b0;
    #2;
    apply_reset();

    // single read: core 1, addr 0x05
    cpu_if.we[1] = 1'b0; cpu_if.addr[1] = 6'h05; cpu_if.req[1] = 1'b1;
    #1;
    chk("stall_same_cycle", cpu_if.stall[1], 1'b1);
    t0 = cyc; stall_cnt = 0; done_at = -1; rd_val = '0;
    repeat (6) begin
      cycle();
      if (snap_stall[1]) stall_cnt++;
      if (snap_done[1]) begin done_at = cyc - 1 - t0; rd_val = snap_rdata; end
    end
    chk("read_done_offset", done_at, 4);
    chk("read_rdata", rd_val, 32'hDEADBEEF);
    chk("read_stall_cycles", stall_cnt, 4);

    // single write: core 2 writes 0x12345678 to 0x3F
    cpu_if.we[2] = 1'b1; cpu_if.addr[2] = 6'h3F; cpu_if.wdata[2] = 32'h12345678;
    cpu_if.req[2] = 1'b1;
    cycle();
    cycle();
    chk("write_gw", snap_gw, 1'b1);
    chk("write_addr", snap_addr, 6'h3F);
    chk("write_wd", snap_wd, 32'h12345678);
`ifdef MEM_ARBITER_SNOOP_INV_EN
    chk("write_inv", {snap_inv_v, snap_inv_m, snap_inv_a}, {1'b1, 4'b1011, 6'h3F});
`endif
    cycle();
    chk("write_done", snap_done, 4'b0100);
    run_until_idle(20);

    // read back the written word from core 0
    cpu_if.we[0] = 1'b0; cpu_if.addr[0] = 6'h3F; cpu_if.req[0] = 1'b1;
    rd_val = '0;
    repeat (6) begin
      cycle();
      if (snap_done[0]) rd_val = snap_rdata;
    end
    chk("readback_rdata", rd_val, 32'h12345678);
    run_until_idle(20);

    // contention: all cores from reset, held continuously
    apply_reset();
    for (int k = 0; k < NCORE; k++) begin
      cpu_if.we[k] = 1'b0; cpu_if.addr[k] = ADDR_W'(k * 3);
    end
    cpu_if.req = '1; keep_req = '1;
    done_log.delete();
    for (int n = 0; n < 60 && done_log.size() < 5; n++) cycle();
    chk("contend_count", done_log.size() >= 5, 1'b1);
    if (done_log.size() >= 5) begin
      chk("contend_order0", done_log[0], 0);
      chk("contend_order1", done_log[1], 1);
      chk("contend_order2", done_log[2], 2);
      chk("contend_order3", done_log[3], 3);
      chk("contend_order4", done_log[4], 0);
    end
    keep_req = '0;
    run_until_idle(80);

    // pointer wrap: serve core 3, then cores 0 and 3 together
    apply_reset();
    cpu_if.we[3] = 1'b1; cpu_if.addr[3] = 6'h0A; cpu_if.wdata[3] = 32'hCAFE0003;
    cpu_if.req[3] = 1'b1;
    run_until_idle(20);
    done_log.delete();
    cpu_if.we[0] = 1'b0; cpu_if.addr[0] = 6'h0A; cpu_if.we[3] = 1'b0;
    cpu_if.req[0] = 1'b1; cpu_if.req[3] = 1'b1;
    run_until_idle(40);
    chk("wrap_count", done_log.size(), 2);
    if (done_log.size() == 2) begin
      chk("wrap_first", done_log[0], 0);
      chk("wrap_second", done_log[1], 3);
    end

    // reset in the middle of a read
    cpu_if.we[1] = 1'b0; cpu_if.addr[1] = 6'h09; cpu_if.req[1] = 1'b1;
    cycle();
    cycle();
    chk("midrst_in_wait", dbg_state, ST_WAIT);
    #2;
    reset_n = 1'b0;
    cpu_if.req = '0;
    #1;
    check_all_zero("midrst");
    model_reset();
    repeat (2) begin
      @(negedge new_clock);
      chk("midrst_hold_done", cpu_if.done, '0);
      chk("midrst_hold_inv", inv_valid, 1'b0);
    end
    reset_n = 1'b1;
    @(posedge new_clock);
    #1;
    chk("midrst_idle", dbg_state, ST_IDLE);
    done_log.delete();
    cpu_if.we[0] = 1'b0; cpu_if.we[1] = 1'b0; cpu_if.we[2] = 1'b0;
    cpu_if.req[2] = 1'b1; cpu_if.req[1] = 1'b1; cpu_if.req[0] = 1'b1;
    run_until_idle(60);
    chk("midrst_count", done_log.size(), 3);
    if (done_log.size() == 3) chk("midrst_first", done_log[0], 0);

    // randomized multi-core traffic
    apply_reset();
    rand_mode = 1'b1;
    repeat (3000) cycle();
    rand_mode = 1'b0;
    run_until_idle(200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #600000;
    n_errors++;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
